// File: rtl/alu_result_stage_if.sv
// Purpose : result-bus bundle between the ALU result stage and its neighbours;
//           carries one result (FS, Y_hi, Y_lo, {C,N,Z,V}) with valid/ready.
// Ports   : vld/fs/y_hi/y_lo/cnzv driven by the master, rdy driven by the slave.
interface alu_result_stage_if #(
  parameter int DW = 32
);
  logic          vld;
  logic          rdy;
  logic [4:0]    fs;
  logic [DW-1:0] y_hi;
  logic [DW-1:0] y_lo;
  logic [3:0]    cnzv;   // {C,N,Z,V}

  modport master (output vld, fs, y_hi, y_lo, cnzv, input rdy);
  modport slave  (input vld, fs, y_hi, y_lo, cnzv, output rdy);
endinterface

// File: rtl/alu_result_stage.sv
// Purpose : registered FIFO stage after the ALU; commits HI/LO and flags on dequeue.
// Latency : 1 cycle from accepted input to head output, no bypass.
// Backpr. : s_in.rdy drops when full or flushing; head held stable while m_out.rdy=0.
//
// Ports:
//   i_clk    - clock, all state on rising edge
//   i_reset  - synchronous active-low reset
//   i_flush  - squash all buffered entries (no commit, incoming push dropped)
//   s_in     - ALU result input (slave side of the result bundle)
//   m_out    - head entry toward writeback (master side of the result bundle)
//   o_hi/o_lo- architectural HI/LO, written by MUL/DIV entries on dequeue
//   o_flags  - {C,N,Z,V} of the last dequeued entry
module alu_result_stage #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  alu_result_stage_if.slave    s_in,
  alu_result_stage_if.master   m_out,
  output logic [DW-1:0]        o_hi,
  output logic [DW-1:0]        o_lo,
  output logic [3:0]           o_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  typedef struct packed {
    logic [4:0]    fs;
    logic [DW-1:0] y_hi;
    logic [DW-1:0] y_lo;
    logic [3:0]    cnzv;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic [3:0]      r_flags;

  entry_t          w_in;
  entry_t          w_head;
  logic            w_in_rdy;
  logic            w_out_vld;
  logic            w_push;
  logic            w_pop;
  logic            w_commit;

  assign w_in      = '{fs: s_in.fs, y_hi: s_in.y_hi, y_lo: s_in.y_lo, cnzv: s_in.cnzv};
  assign w_head    = r_mem[r_rd_ptr];
  assign w_in_rdy  = (r_cnt != FULL) && !i_flush;
  assign w_out_vld = (r_cnt != '0);
  assign w_push    = s_in.vld && w_in_rdy;
  assign w_pop     = w_out_vld && m_out.rdy;
  // A flush squashes the head too, so a pop in the same cycle must not commit.
  assign w_commit  = w_pop && !i_flush;

  // Pointers and occupancy. Flush resets them like reset does, but the
  // architectural registers below are left alone.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: empty slots are masked at the output.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  // HI/LO and flags change only when an entry actually leaves the stage.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_flags <= '0;
    end else if (w_commit) begin
      r_flags <= w_head.cnzv;
      if (w_head.fs == FS_MUL || w_head.fs == FS_DIV) begin
        r_hi <= w_head.y_hi;
        r_lo <= w_head.y_lo;
      end
    end
  end

  assign s_in.rdy    = w_in_rdy;
  assign m_out.vld   = w_out_vld;
  assign m_out.fs    = w_out_vld ? w_head.fs   : '0;
  assign m_out.y_hi  = w_out_vld ? w_head.y_hi : '0;
  assign m_out.y_lo  = w_out_vld ? w_head.y_lo : '0;
  assign m_out.cnzv  = w_out_vld ? w_head.cnzv : '0;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_flags     = r_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Purpose : directed self-checking bench for alu_result_stage.
// Latency : checks head one edge after each accepted push.
// Backpr. : exercises full-stage stall, push/pop overlap and flush.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic [3:0]  flags;
  int          errors = 0;
  int          checks = 0;

  alu_result_stage_if #(.DW(32)) in_if ();
  alu_result_stage_if #(.DW(32)) out_if ();

  alu_result_stage #(.DW(32), .DEPTH(2)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (flush),
    .s_in    (in_if),
    .m_out   (out_if),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_flags (flags)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] fs, input logic [31:0] yh,
                          input logic [31:0] yl, input logic [3:0] f);
    in_if.vld  = v;
    in_if.fs   = fs;
    in_if.y_hi = yh;
    in_if.y_lo = yl;
    in_if.cnzv = f;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_if.rdy = 1'b1;
    drive_in(1'b1, 5'h1E, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    tick();
    tick();
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_if.vld); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags); end
    checks++; if (out_if.fs !== 5'h0 || out_if.y_lo !== 32'h0) begin errors++; $display("FAIL reset_head_zero fs=%h y_lo=%h exp=0", out_if.fs, out_if.y_lo); end
    reset = 1'b1;
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    out_if.rdy = 1'b0;
    tick();
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_if.rdy); end
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL reset_release_valid got=%b exp=0", out_if.vld); end
  endtask

  task automatic test_single();
    out_if.rdy = 1'b0;
    drive_in(1'b1, 5'h0C, 32'h0000_0000, 32'h0000_0F00, 4'b0000);
    tick();
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (out_if.vld !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_if.vld); end
    checks++; if (out_if.fs !== 5'h0C) begin errors++; $display("FAIL single_fs got=%h exp=0c", out_if.fs); end
    checks++; if (out_if.y_lo !== 32'h0000_0F00) begin errors++; $display("FAIL single_y_lo got=%h exp=00000f00", out_if.y_lo); end
    out_if.rdy = 1'b1;
    tick();
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", out_if.vld); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL single_flags got=%b exp=0000", flags); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL single_hilo hi=%h lo=%h exp=0/0", hi, lo); end
  endtask

  task automatic test_full();
    out_if.rdy = 1'b0;
    drive_in(1'b1, 5'h01, 32'h0, 32'hAAAA_0001, 4'b1000);   // A
    tick();
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_a got=%b exp=1", in_if.rdy); end
    drive_in(1'b1, 5'h02, 32'h0, 32'hBBBB_0002, 4'b0100);   // B
    tick();
    drive_in(1'b1, 5'h03, 32'h0, 32'hCCCC_0003, 4'b0010);   // C, held by upstream
    checks++; if (in_if.rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_after_b got=%b exp=0", in_if.rdy); end
    tick();
    tick();
    checks++; if (in_if.rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_held got=%b exp=0", in_if.rdy); end
    checks++; if (out_if.y_lo !== 32'hAAAA_0001) begin errors++; $display("FAIL full_head_stable got=%h exp=aaaa0001", out_if.y_lo); end
    out_if.rdy = 1'b1;
    tick();                                                  // pop A, C not accepted
    checks++; if (out_if.y_lo !== 32'hBBBB_0002) begin errors++; $display("FAIL full_head_b got=%h exp=bbbb0002", out_if.y_lo); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL full_flags_a got=%b exp=1000", flags); end
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_reopen got=%b exp=1", in_if.rdy); end
    tick();                                                  // pop B, push C
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (out_if.y_lo !== 32'hCCCC_0003) begin errors++; $display("FAIL full_head_c got=%h exp=cccc0003", out_if.y_lo); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL full_flags_b got=%b exp=0100", flags); end
    tick();                                                  // pop C
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL full_flags_c got=%b exp=0010", flags); end
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL full_drained got=%b exp=0 (duplicate?)", out_if.vld); end
  endtask

  task automatic test_back_to_back();
    out_if.rdy = 1'b0;
    drive_in(1'b1, 5'h02, 32'h0, 32'h0000_0100, 4'h0);
    tick();
    out_if.rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, 5'h02, 32'h0, 32'h0000_0100 + 32'(i + 1), 4'(i + 1));
      checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, in_if.rdy); end
      tick();
      checks++; if (out_if.vld !== 1'b1 || out_if.y_lo !== 32'h0000_0100 + 32'(i + 1))
        begin errors++; $display("FAIL b2b_head[%0d] vld=%b y_lo=%h exp=1/%h", i, out_if.vld, out_if.y_lo, 32'h0000_0100 + 32'(i + 1)); end
      checks++; if (flags !== 4'(i)) begin errors++; $display("FAIL b2b_flags[%0d] got=%h exp=%h", i, flags, 4'(i)); end
    end
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    tick();
    checks++; if (out_if.vld !== 1'b0 || flags !== 4'hA) begin errors++; $display("FAIL b2b_drain vld=%b flags=%h exp=0/a", out_if.vld, flags); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL b2b_hilo hi=%h lo=%h exp=0/0", hi, lo); end
  endtask

  task automatic test_mul();
    out_if.rdy = 1'b0;
    drive_in(1'b1, 5'h1E, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0101);
    tick();
    out_if.rdy = 1'b1;
    drive_in(1'b1, 5'h0E, 32'hFFFF_FFFF, 32'h0000_00F0, 4'b0010);  // SRA
    tick();
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mul_hi got=%h exp=deadbeef", hi); end
    checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL mul_lo got=%h exp=12345678", lo); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL mul_flags got=%b exp=0101", flags); end
    tick();
    checks++; if (hi !== 32'hDEAD_BEEF || lo !== 32'h1234_5678) begin errors++; $display("FAIL sra_hilo hi=%h lo=%h exp=deadbeef/12345678", hi, lo); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL sra_flags got=%b exp=0010", flags); end
  endtask

  task automatic test_flush();
    out_if.rdy = 1'b0;
    drive_in(1'b1, 5'h1F, 32'hAAAA_0001, 32'h5555_0002, 4'b1001);
    tick();
    drive_in(1'b1, 5'h03, 32'h0, 32'h0000_0007, 4'b0110);
    tick();
    checks++; if (out_if.vld !== 1'b1 || in_if.rdy !== 1'b0) begin errors++; $display("FAIL flush_pre vld=%b rdy=%b exp=1/0", out_if.vld, in_if.rdy); end
    flush = 1'b1;
    out_if.rdy = 1'b1;
    drive_in(1'b1, 5'h1E, 32'h0000_0001, 32'h0000_0002, 4'b1111);
    #1;
    checks++; if (in_if.rdy !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_if.rdy); end
    tick();
    flush = 1'b0;
    out_if.rdy = 1'b0;
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (out_if.vld !== 1'b0 || out_if.fs !== 5'h0) begin errors++; $display("FAIL flush_empty vld=%b fs=%h exp=0/0", out_if.vld, out_if.fs); end
    checks++; if (hi !== 32'hDEAD_BEEF || lo !== 32'h1234_5678) begin errors++; $display("FAIL flush_hilo hi=%h lo=%h exp=deadbeef/12345678", hi, lo); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL flush_flags got=%b exp=0010", flags); end
    tick();
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL flush_push_lost got=%b exp=0", out_if.vld); end
    drive_in(1'b1, 5'h1F, 32'h0000_0011, 32'h0000_0022, 4'b0011);
    tick();
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (out_if.vld !== 1'b1 || out_if.y_hi !== 32'h0000_0011) begin errors++; $display("FAIL post_flush_head vld=%b y_hi=%h exp=1/00000011", out_if.vld, out_if.y_hi); end
    out_if.rdy = 1'b1;
    tick();
    checks++; if (hi !== 32'h0000_0011 || lo !== 32'h0000_0022) begin errors++; $display("FAIL div_commit hi=%h lo=%h exp=00000011/00000022", hi, lo); end
    checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL div_flags got=%b exp=0011", flags); end
  endtask

  initial begin
    out_if.rdy = 1'b0;
    drive_in(1'b0, 5'h0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_mul();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
